// File: rtl/edc_pkg.sv
// Shared SECDED code definitions: check-bit count, codeword position map and
// encoder. Used by the decode pipeline and the future edc_encoder.
package edc_pkg;

   localparam int unsigned MAX_DW = 128;
   localparam int unsigned MAX_EW = 9;

   typedef enum logic [1:0] {
      CLS_CLEAN,
      CLS_CORR,
      CLS_UNCORR
   } edc_cls_e;

   // Smallest r with 2^r >= dw + r + 1
   function automatic int unsigned hamming_bits(input int unsigned dw);
      int unsigned r;
      r = 0;
      for (int unsigned k = 1; k < 16; k++)
         if (r == 0 && (32'd1 << k) >= dw + k + 32'd1) r = k;
      return r;
   endfunction

   function automatic int unsigned ecc_width(input int unsigned dw);
      return hamming_bits(dw) + 32'd1;
   endfunction

   // Codeword position of data bit idx (powers of two are check-bit slots)
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned cnt, pos;
      cnt = 0;
      pos = 0;
      for (int unsigned p = 1; p <= MAX_DW + MAX_EW; p++) begin
         if ((p & (p - 32'd1)) != 0) begin
            if (cnt == idx && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

   function automatic logic [MAX_EW-1:0] encode(input logic [MAX_DW-1:0] dat,
                                                input int unsigned       dw);
      logic [MAX_EW-1:0] ecc;
      int unsigned       r, pos;
      logic              par;
      r   = hamming_bits(dw);
      ecc = '0;
      par = 1'b0;
      for (int unsigned i = 0; i < MAX_DW; i++) begin
         pos = data_pos(i);
         if (i < dw && dat[i]) begin
            par = ~par;
            for (int unsigned k = 0; k < MAX_EW - 1; k++)
               if (k < r && pos[k]) ecc[k] = ~ecc[k];
         end
      end
      for (int unsigned k = 0; k < MAX_EW - 1; k++)
         if (k < r) par = par ^ ecc[k];
      ecc[r] = par;
      return ecc;
   endfunction

endpackage

// File: rtl/edc_syndrome.sv
// Combinational SECDED syndrome (recomputed XOR received Hamming bits) and
// overall parity of the received codeword.
module edc_syndrome
   import edc_pkg::*;
#(
   parameter int unsigned WB_DWIDTH = 32,
   parameter int unsigned ECC_WIDTH = ecc_width(WB_DWIDTH)
) (
   input  logic [WB_DWIDTH-1:0] dat,
   input  logic [ECC_WIDTH-1:0] ecc,
   output logic [ECC_WIDTH-2:0] syn,
   output logic                 par
);

   logic [MAX_EW-1:0] calc;
   logic              calc_unused;

   assign calc        = encode(MAX_DW'(dat), WB_DWIDTH);
   assign syn         = calc[ECC_WIDTH-2:0] ^ ecc[ECC_WIDTH-2:0];
   assign par         = ^{dat, ecc};
   // Recomputed overall-parity bit is redundant here: par already covers it
   assign calc_unused = ^calc[MAX_EW-1:ECC_WIDTH-1];

endmodule

// File: rtl/edc_secded_pipe.sv
// Two-stage SECDED check/correct pipeline with valid/ready flow control,
// saturating error counters, first-error capture and sticky uncorrectable IRQ.
module edc_secded_pipe
   import edc_pkg::*;
#(
   parameter int unsigned WB_DWIDTH = 32,
   parameter int unsigned ECC_WIDTH = ecc_width(WB_DWIDTH),
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WB_DWIDTH-1:0] i_dat,
   input  logic [ECC_WIDTH-1:0] i_ecc,
   input  logic [31:0]          i_adr,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [WB_DWIDTH-1:0] o_dat,
   output logic [31:0]          o_adr,
   output logic                 o_corr,
   output logic                 o_uncorr,
   input  logic                 i_cnt_clr,
   output logic [CNT_WIDTH-1:0] o_corr_cnt,
   output logic [CNT_WIDTH-1:0] o_uncorr_cnt,
   output logic [31:0]          o_err_adr,
   output logic [ECC_WIDTH-1:0] o_err_syn,
   output logic                 o_err_irq
);

   localparam int unsigned HB = ECC_WIDTH - 1;

   logic                 advance, out_hs;
   logic [HB-1:0]        syn_c, s1_syn;
   logic                 par_c, s1_par, s1_valid;
   logic [WB_DWIDTH-1:0] s1_dat, flip, dat_c;
   logic [31:0]          s1_adr;
   edc_cls_e             cls;
   logic [ECC_WIDTH-1:0] s2_syn;
   logic                 cap_vld;

   assign advance = !o_valid || i_ready;
   assign o_ready = advance;
   assign out_hs  = o_valid && i_ready;

   edc_syndrome #(
      .WB_DWIDTH(WB_DWIDTH),
      .ECC_WIDTH(ECC_WIDTH)
   ) u_syndrome (
      .dat(i_dat),
      .ecc(i_ecc),
      .syn(syn_c),
      .par(par_c)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
         s1_dat   <= '0;
         s1_adr   <= '0;
      end else if (advance) begin
         s1_valid <= i_valid;
         s1_syn   <= syn_c;
         s1_par   <= par_c;
         s1_dat   <= i_dat;
         s1_adr   <= i_adr;
      end
   end

   for (genvar gi = 0; gi < WB_DWIDTH; gi++) begin : g_flip
      localparam int unsigned POS = data_pos(gi);
      assign flip[gi] = (32'(s1_syn) == POS);
   end

   always_comb begin
      cls   = CLS_CLEAN;
      dat_c = s1_dat;
      if (s1_par) begin
         // Zero or power-of-two syndrome: the flipped bit is a check bit
         if ((s1_syn & (s1_syn - HB'(1))) == '0) begin
            cls = CLS_CORR;
         end else if (|flip) begin
            cls   = CLS_CORR;
            dat_c = s1_dat ^ flip;
         end else begin
            cls = CLS_UNCORR;
         end
      end else if (s1_syn != '0) begin
         cls = CLS_UNCORR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid  <= 1'b0;
         o_dat    <= '0;
         o_adr    <= '0;
         o_corr   <= 1'b0;
         o_uncorr <= 1'b0;
         s2_syn   <= '0;
      end else if (advance) begin
         o_valid  <= s1_valid;
         o_dat    <= dat_c;
         o_adr    <= s1_adr;
         o_corr   <= s1_valid && (cls == CLS_CORR);
         o_uncorr <= s1_valid && (cls == CLS_UNCORR);
         s2_syn   <= {s1_par, s1_syn};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_cnt_clr) begin
         o_corr_cnt   <= '0;
         o_uncorr_cnt <= '0;
         o_err_adr    <= '0;
         o_err_syn    <= '0;
         o_err_irq    <= 1'b0;
         cap_vld      <= 1'b0;
      end else if (out_hs) begin
         if (o_corr && o_corr_cnt != '1)
            o_corr_cnt <= o_corr_cnt + CNT_WIDTH'(1);
         if (o_uncorr && o_uncorr_cnt != '1)
            o_uncorr_cnt <= o_uncorr_cnt + CNT_WIDTH'(1);
         if ((o_corr || o_uncorr) && !cap_vld) begin
            cap_vld   <= 1'b1;
            o_err_adr <= o_adr;
            o_err_syn <= s2_syn;
         end
         if (o_uncorr) o_err_irq <= 1'b1;
      end
   end

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Scoreboard bench for edc_secded_pipe (32-bit data, 7 check bits).
module tb_edc_secded_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_valid, o_ready, o_valid, i_ready;
   logic [31:0] i_dat, i_adr, o_dat, o_adr, o_err_adr;
   logic [6:0]  i_ecc, o_err_syn;
   logic        o_corr, o_uncorr, i_cnt_clr, o_err_irq;
   logic [15:0] o_corr_cnt, o_uncorr_cnt;

   edc_secded_pipe #(
      .WB_DWIDTH(32),
      .CNT_WIDTH(16)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_dat(i_dat), .i_ecc(i_ecc), .i_adr(i_adr), .o_valid(o_valid),
      .i_ready(i_ready), .o_dat(o_dat), .o_adr(o_adr), .o_corr(o_corr),
      .o_uncorr(o_uncorr), .i_cnt_clr(i_cnt_clr), .o_corr_cnt(o_corr_cnt),
      .o_uncorr_cnt(o_uncorr_cnt), .o_err_adr(o_err_adr), .o_err_syn(o_err_syn),
      .o_err_irq(o_err_irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] dat;
      logic [31:0] adr;
      logic        corr;
      logic        uncorr;
      logic [6:0]  syn;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] st_dat[$];
   logic [6:0]  st_ecc[$];
   logic [31:0] st_adr[$];

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned m_corr, m_uncorr;
   logic [31:0] m_adr;
   logic [6:0]  m_syn;
   logic        m_cap, m_irq;

   // Reference encoder: XOR of codeword positions of set data bits
   function automatic logic [6:0] tb_encode(input logic [31:0] d);
      int unsigned acc, bi;
      logic [5:0]  ham;
      acc = 0;
      bi  = 0;
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[bi]) acc = acc ^ pos;
            bi++;
         end
      end
      ham = acc[5:0];
      return {(^d) ^ (^ham), ham};
   endfunction

   function automatic exp_t tb_model(input logic [31:0] d, input logic [6:0] e,
                                     input logic [31:0] a);
      exp_t        r;
      int unsigned s, bi, hit;
      logic        p;
      s   = 0;
      bi  = 0;
      hit = 99;
      for (int unsigned k = 0; k < 6; k++)
         if (e[k]) s = s ^ (32'd1 << k);
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[bi]) s = s ^ pos;
            bi++;
         end
      end
      bi = 0;
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (pos == s) hit = bi;
            bi++;
         end
      end
      p        = (^d) ^ (^e);
      r.dat    = d;
      r.adr    = a;
      r.corr   = 1'b0;
      r.uncorr = 1'b0;
      r.syn    = {p, 6'(s)};
      if (!p && s == 0) begin
      end else if (!p || s > 38) begin
         r.uncorr = 1'b1;
      end else begin
         r.corr = 1'b1;
         if (hit < 32) r.dat[hit] = ~r.dat[hit];
      end
      return r;
   endfunction

   task automatic add(input logic [31:0] d, input logic [6:0] e, input logic [31:0] a);
      st_dat.push_back(d);
      st_ecc.push_back(e);
      st_adr.push_back(a);
   endtask

   task automatic model_clear();
      m_corr   = 0;
      m_uncorr = 0;
      m_adr    = '0;
      m_syn    = '0;
      m_cap    = 1'b0;
      m_irq    = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_valid   = 1'b0;
      i_ready   = 1'b1;
      i_cnt_clr = 1'b0;
      i_dat     = '0;
      i_ecc     = '0;
      i_adr     = '0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      sb.delete();
      model_clear();
   endtask

   task automatic pulse_clear();
      @(negedge i_clk);
      i_cnt_clr = 1'b1;
      @(negedge i_clk);
      i_cnt_clr = 1'b0;
      model_clear();
   endtask

   // Drives the staged beats with the cyclic i_ready pattern; checks each output beat
   task automatic run_scoreboard(input logic [3:0] rpat, input string tag);
      exp_t        e;
      int unsigned idx, cyc, budget;
      idx    = 0;
      cyc    = 0;
      budget = 10 * st_dat.size() + 40;
      while ((idx < st_dat.size() || sb.size() != 0) && cyc < budget) begin
         @(negedge i_clk);
         i_ready = rpat[cyc % 4];
         if (idx < st_dat.size()) begin
            i_valid = 1'b1;
            i_dat   = st_dat[idx];
            i_ecc   = st_ecc[idx];
            i_adr   = st_adr[idx];
         end else begin
            i_valid = 1'b0;
         end
         #1;
         if (o_valid && i_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
               $display("FAIL %s extra_beat: got adr %h, required no beat", tag, o_adr);
            end else begin
               n_pass++;
               e = sb.pop_front();
               n_chk++;
               if (o_dat !== e.dat) $display("FAIL %s dat@%h: got %h, required %h", tag, e.adr, o_dat, e.dat);
               else n_pass++;
               n_chk++;
               if (o_adr !== e.adr) $display("FAIL %s adr: got %h, required %h", tag, o_adr, e.adr);
               else n_pass++;
               n_chk++;
               if (o_corr !== e.corr) $display("FAIL %s corr@%h: got %b, required %b", tag, e.adr, o_corr, e.corr);
               else n_pass++;
               n_chk++;
               if (o_uncorr !== e.uncorr) $display("FAIL %s uncorr@%h: got %b, required %b", tag, e.adr, o_uncorr, e.uncorr);
               else n_pass++;
               if ((e.corr || e.uncorr) && !m_cap) begin
                  m_cap = 1'b1;
                  m_adr = e.adr;
                  m_syn = e.syn;
               end
               if (e.corr && m_corr != 65535) m_corr++;
               if (e.uncorr && m_uncorr != 65535) m_uncorr++;
               if (e.uncorr) m_irq = 1'b1;
            end
         end
         if (i_valid && o_ready) begin
            sb.push_back(tb_model(i_dat, i_ecc, i_adr));
            idx++;
         end
         cyc++;
      end
      n_chk++;
      if (idx != st_dat.size() || sb.size() != 0)
         $display("FAIL %s drain: got %0d sent / %0d pending, required %0d / 0", tag, idx, sb.size(), st_dat.size());
      else n_pass++;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      #1;
      st_dat.delete();
      st_ecc.delete();
      st_adr.delete();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", o_valid); else n_pass++;
      n_chk++; if (o_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", o_ready); else n_pass++;
      n_chk++; if (o_dat !== 32'd0) $display("FAIL rst_dat: got %h, required 0", o_dat); else n_pass++;
      n_chk++; if ({o_corr, o_uncorr} !== 2'b00) $display("FAIL rst_flags: got %b, required 00", {o_corr, o_uncorr}); else n_pass++;
      n_chk++; if ({o_corr_cnt, o_uncorr_cnt} !== 32'd0) $display("FAIL rst_cnt: got %h, required 0", {o_corr_cnt, o_uncorr_cnt}); else n_pass++;
      n_chk++; if ({o_err_adr, o_err_syn, o_err_irq} !== 40'd0) $display("FAIL rst_capture: got %h, required 0", {o_err_adr, o_err_syn, o_err_irq}); else n_pass++;
   endtask

   task automatic test_clean();
      logic [31:0] d;
      add(32'h0, 7'h00, 32'h1000);
      for (int i = 0; i < 6; i++) begin
         d = $urandom;
         add(d, tb_encode(d), 32'h1001 + 32'(i));
      end
      run_scoreboard(4'hF, "clean");
      n_chk++; if (o_corr_cnt !== 16'd0) $display("FAIL clean_corr_cnt: got %0d, required 0", o_corr_cnt); else n_pass++;
      n_chk++; if (o_uncorr_cnt !== 16'd0) $display("FAIL clean_uncorr_cnt: got %0d, required 0", o_uncorr_cnt); else n_pass++;
   endtask

   task automatic test_single();
      logic [31:0] d;
      logic [6:0]  e;
      add(32'h1, 7'h00, 32'h10);
      for (int b = 0; b < 32; b++) begin
         d = $urandom;
         add(d ^ (32'd1 << b), tb_encode(d), 32'h20 + 32'(b));
      end
      d = $urandom;
      e = tb_encode(d);
      for (int k = 0; k < 7; k++) add(d, e ^ (7'd1 << k), 32'h40 + 32'(k));
      run_scoreboard(4'hF, "single");
      n_chk++; if (o_corr_cnt !== 16'(m_corr)) $display("FAIL single_corr_cnt: got %0d, required %0d", o_corr_cnt, m_corr); else n_pass++;
      n_chk++; if (o_err_syn !== 7'h43) $display("FAIL single_err_syn: got %h, required 43", o_err_syn); else n_pass++;
      n_chk++; if (o_err_adr !== 32'h10) $display("FAIL single_err_adr: got %h, required 10", o_err_adr); else n_pass++;
      n_chk++; if (o_err_irq !== 1'b0) $display("FAIL single_irq: got %b, required 0", o_err_irq); else n_pass++;
   endtask

   task automatic test_double();
      logic [31:0] d;
      int unsigned b1, b2;
      add(32'h3, 7'h00, 32'h30);
      add(32'h0, 7'h7F, 32'h31);
      for (int i = 0; i < 4; i++) begin
         d  = $urandom;
         b1 = $urandom_range(0, 31);
         b2 = (b1 + $urandom_range(1, 31)) % 32;
         add(d ^ (32'd1 << b1) ^ (32'd1 << b2), tb_encode(d), 32'h32 + 32'(i));
      end
      run_scoreboard(4'hF, "double");
      n_chk++; if (o_uncorr_cnt !== 16'(m_uncorr)) $display("FAIL double_uncorr_cnt: got %0d, required %0d", o_uncorr_cnt, m_uncorr); else n_pass++;
      n_chk++; if (o_err_irq !== 1'b1) $display("FAIL double_irq: got %b, required 1", o_err_irq); else n_pass++;
      n_chk++; if (o_err_adr !== m_adr) $display("FAIL double_err_adr: got %h, required %h", o_err_adr, m_adr); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         add(d, tb_encode(d), 32'h800 + 32'(i));
      end
      run_scoreboard(4'b1001, "bp");
      n_chk++; if (o_corr_cnt !== 16'(m_corr)) $display("FAIL bp_corr_cnt: got %0d, required %0d", o_corr_cnt, m_corr); else n_pass++;
      n_chk++; if (o_uncorr_cnt !== 16'(m_uncorr)) $display("FAIL bp_uncorr_cnt: got %0d, required %0d", o_uncorr_cnt, m_uncorr); else n_pass++;
   endtask

   task automatic test_saturate();
      logic found;
      pulse_clear();
      for (int i = 0; i < 65535; i++) begin
         @(negedge i_clk);
         i_valid = 1'b1;
         i_dat   = 32'h1;
         i_ecc   = 7'h00;
         i_adr   = 32'h500;
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      #1;
      n_chk++; if (o_corr_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h, required ffff", o_corr_cnt); else n_pass++;
      @(negedge i_clk);
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      #1;
      n_chk++; if (o_corr_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h, required ffff", o_corr_cnt); else n_pass++;
      @(negedge i_clk);
      i_valid = 1'b1;
      i_dat   = 32'h3;
      i_adr   = 32'h600;
      @(negedge i_clk);
      i_valid = 1'b0;
      found   = 1'b0;
      for (int n = 0; n < 6 && !found; n++) begin
         @(negedge i_clk);
         #1;
         if (o_valid) begin
            found     = 1'b1;
            i_cnt_clr = 1'b1;
            n_chk++; if (o_dat !== 32'h3) $display("FAIL clr_pipe_dat: got %h, required 3", o_dat); else n_pass++;
            n_chk++; if (o_uncorr !== 1'b1) $display("FAIL clr_pipe_uncorr: got %b, required 1", o_uncorr); else n_pass++;
         end
      end
      n_chk++; if (!found) $display("FAIL clr_beat_timeout: got no beat, required one"); else n_pass++;
      @(negedge i_clk);
      i_cnt_clr = 1'b0;
      #1;
      n_chk++; if ({o_corr_cnt, o_uncorr_cnt} !== 32'd0) $display("FAIL clr_wins_cnt: got %h, required 0", {o_corr_cnt, o_uncorr_cnt}); else n_pass++;
      n_chk++; if ({o_err_adr, o_err_syn} !== 39'd0) $display("FAIL clr_wins_capture: got %h, required 0", {o_err_adr, o_err_syn}); else n_pass++;
      n_chk++; if (o_err_irq !== 1'b0) $display("FAIL clr_wins_irq: got %b, required 0", o_err_irq); else n_pass++;
      model_clear();
   endtask

   task automatic test_capture_reset();
      pulse_clear();
      add(32'h1, 7'h00, 32'h100);
      add(32'h2, 7'h00, 32'h200);
      run_scoreboard(4'hF, "capture");
      n_chk++; if (o_err_adr !== 32'h100) $display("FAIL cap_adr: got %h, required 100", o_err_adr); else n_pass++;
      n_chk++; if (o_err_syn !== m_syn) $display("FAIL cap_syn: got %h, required %h", o_err_syn, m_syn); else n_pass++;
      n_chk++; if (o_corr_cnt !== 16'd2) $display("FAIL cap_cnt: got %0d, required 2", o_corr_cnt); else n_pass++;
      @(negedge i_clk);
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_dat   = 32'h1;
      i_ecc   = 7'h00;
      i_adr   = 32'h300;
      @(negedge i_clk);
      i_dat = 32'h3;
      i_adr = 32'h400;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      #1;
      n_chk++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %b, required 0", o_valid); else n_pass++;
      repeat (3) @(negedge i_clk);
      #1;
      n_chk++; if (o_valid !== 1'b0) $display("FAIL flush_late_valid: got %b, required 0", o_valid); else n_pass++;
      n_chk++; if ({o_corr_cnt, o_uncorr_cnt} !== 32'd0) $display("FAIL flush_cnt: got %h, required 0", {o_corr_cnt, o_uncorr_cnt}); else n_pass++;
      n_chk++; if (o_err_irq !== 1'b0) $display("FAIL flush_irq: got %b, required 0", o_err_irq); else n_pass++;
      model_clear();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_back_to_back();
      test_saturate();
      test_capture_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/edc_secded_pipe.md
EDC_SECDED_PIPE -- requirements
Module: edc_secded_pipe

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- WB_DWIDTH, 32, data width; legal values 32, 64, 128.
- ECC_WIDTH, derived (7/8/9 for 32/64/128), check bits: Hamming bits plus one overall parity bit.
- CNT_WIDTH, 16, width of the error counters.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, sole clock; all state on rising edge.
- i_rst_n, in, 1, synchronous active-low reset.
- i_valid, in, 1, input beat valid.
- o_ready, out, 1, block accepts a beat.
- i_dat, in, WB_DWIDTH, raw data from main memory.
- i_ecc, in, ECC_WIDTH, stored check bits.
- i_adr, in, 32, address tag carried with the beat.
- o_valid, out, 1, output beat valid.
- i_ready, in, 1, downstream accepts.
- o_dat, out, WB_DWIDTH, corrected data.
- o_adr, out, 32, address tag of the output beat.
- o_corr, out, 1, output beat had a corrected single error.
- o_uncorr, out, 1, output beat had an uncorrectable double error.
- i_cnt_clr, in, 1, clears counters, capture registers and IRQ.
- o_corr_cnt, out, CNT_WIDTH, corrected-beat count.
- o_uncorr_cnt, out, CNT_WIDTH, uncorrectable-beat count.
- o_err_adr, out, 32, address of first error since clear.
- o_err_syn, out, ECC_WIDTH, syndrome and parity of first error since clear.
- o_err_irq, out, 1, level; uncorrectable seen since clear.
REQ-003 SHALL use one clock, i_clk; reset i_rst_n SHALL be synchronous and active-low.

Function
REQ-004 Code layout SHALL be: codeword positions 1..N; Hamming check bit k at position 2^k; data bits fill the remaining positions in ascending order, LSB first; ecc[k] (k<ECC_WIDTH-1) = XOR of data bits whose position has bit k set; ecc[MSB] = XOR of all data and all lower ecc bits.
REQ-005 Stage 1 SHALL register the syndrome s (recomputed XOR received Hamming bits), overall parity p, data and address.
REQ-006 Stage 2 SHALL classify and correct:
- s=0, p=0: clean.
- p=1, s=0 or s a power of two: check-bit error, data unchanged, o_corr=1.
- p=1, s a data position: flip that bit, o_corr=1.
- p=1, s>N: o_uncorr=1, data unchanged.
- p=0, s!=0: o_uncorr=1, data unchanged.
REQ-007 Latency SHALL be 2 cycles from an accepted input to o_valid; throughput SHALL be one beat per cycle without backpressure.
REQ-008 Pipeline SHALL advance when (!o_valid || i_ready); o_ready SHALL equal that term; no beat SHALL be dropped or duplicated under any i_ready pattern.
REQ-009 o_dat, o_adr, o_corr and o_uncorr SHALL hold stable while o_valid=1 and i_ready=0.
REQ-010 Counters SHALL increment only on an output handshake (o_valid && i_ready) with o_corr or o_uncorr set, and SHALL saturate at all-ones.
REQ-011 o_err_adr/o_err_syn SHALL capture the first erroneous handshaked beat after reset or clear; later errors SHALL NOT overwrite them.
REQ-012 o_err_irq SHALL set on a handshaked uncorrectable beat and SHALL clear only on i_cnt_clr or reset.
REQ-013 If i_cnt_clr coincides with an error handshake, clear SHALL win: counters 0, capture empty, IRQ 0.
REQ-014 i_cnt_clr SHALL NOT affect the data pipeline.

Reset
REQ-015 On reset: stage valids 0, o_valid=0, o_ready=1 in the first cycle after reset, counters 0, o_err_adr=0, o_err_syn=0, o_err_irq=0, o_dat=0, o_corr=0, o_uncorr=0.
REQ-016 Reset mid-stream SHALL discard in-flight beats without counting them.

Structure
REQ-017 Package edc_pkg SHALL hold the ECC_WIDTH derivation function, the position-map function and the encode function, shared with the future edc_encoder.
REQ-018 One sub-module, edc_syndrome (combinational syndrome/parity), SHALL be instantiated in stage 1.

Verification
REQ-019 dat=0x00000000, ecc=0x00, i_ready=1 -> o_dat=0 after 2 cycles, o_corr=0, o_uncorr=0, counters unchanged.
REQ-020 dat=0x00000001, ecc=0x00 (data bit 0 at position 3) -> o_dat=0, o_corr=1, o_corr_cnt=1, o_err_syn low bits=3, p=1.
REQ-021 dat=0x00000003, ecc=0x00 (positions 3 and 5, s=6, p=0) -> o_dat=0x3, o_uncorr=1, o_err_irq=1, o_uncorr_cnt=1.
REQ-022 Stream of 8 beats with i_ready toggling 1,0,0,1 -> all 8 beats out, in order, unchanged, no loss.
REQ-023 o_corr_cnt preset to 0xFFFF plus one corrected beat -> stays 0xFFFF; i_cnt_clr in the same cycle -> 0.
REQ-024 Two errors at adr 0x100 then 0x200 -> o_err_adr=0x100; i_rst_n=0 with 2 beats in flight -> o_valid=0 and counts 0.
